// File: rtl/requant_stage_pkg.sv
// Shared constants and types for the requantisation stage and its neighbours.
package requant_stage_pkg;

    // Default geometry of the accumulator stream
    localparam int unsigned DEF_LANES  = 8;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned DEF_SHIFT  = 8;
    localparam int unsigned DEF_ADDR_W = 9;

    // Field widths
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned SCALE_W = 8;
    localparam int unsigned CFG_W   = 16;

    // Saturation limits of the signed 8-bit result
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // Packed lane bus widths shared with the weight cache and the matmul array
    localparam int unsigned ACC_BUS_W = DEF_LANES * DEF_ACC_W;
    localparam int unsigned OUT_BUS_W = DEF_LANES * OUT_W;

    // Job phase
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_ACCEPT = 2'd1,
        PH_DRAIN  = 2'd2
    } phase_t;

endpackage

// File: rtl/requant_stage_lane.sv
// One lane: scale multiply (stage B), then round, bias and saturate (stage C).
module requant_lane
    import requant_stage_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [ACC_W-1:0]   i_acc,
    input  logic [SCALE_W-1:0] i_scale,
    input  logic [OUT_W-1:0]   i_bias,
    output logic [OUT_W-1:0]   o_y
);

    // Product width: signed accumulator times zero-extended 9-bit scale
    localparam int unsigned PW = ACC_W + SCALE_W + 1;
    localparam logic signed [PW-1:0] ROUND = PW'(1) <<< (SHIFT - 1);
    localparam logic signed [PW-1:0] Y_MAX = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] Y_MIN = PW'(SAT_MIN);

    logic signed [PW-1:0]    w_p;
    logic signed [PW-1:0]    w_r;
    logic signed [PW-1:0]    w_y;
    logic        [OUT_W-1:0] w_sat;
    logic signed [PW-1:0]    r_p;
    logic signed [OUT_W-1:0] r_bias;
    logic        [OUT_W-1:0] r_y;

    assign w_p = PW'($signed(i_acc)) * PW'($signed({1'b0, i_scale}));
    assign w_r = (r_p + ROUND) >>> SHIFT;
    assign w_y = w_r + PW'(r_bias);

    // Clamp the biased result into the signed 8-bit range
    always_comb begin
        w_sat = w_y[OUT_W-1:0];
        if (w_y > Y_MAX) begin
            w_sat = OUT_W'(SAT_MAX);
        end else if (w_y < Y_MIN) begin
            w_sat = OUT_W'(SAT_MIN);
        end
    end

    // Stage B (product, bias) and stage C (result) share the global advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_bias <= '0;
            r_y    <= '0;
        end else if (i_en) begin
            r_p    <= w_p;
            r_bias <= $signed(i_bias);
            r_y    <= w_sat;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/requant_stage.sv
// Per-channel requantisation of accumulator beats into packed saturated int8 lanes.
module requant_stage
    import requant_stage_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned SHIFT  = DEF_SHIFT,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CFG_W-1:0]         out_channels,
    input  logic [CFG_W-1:0]         row_groups,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*ACC_W-1:0]   s_data,
    output logic [ADDR_W-1:0]        scale_addr,
    output logic [ADDR_W-1:0]        bias_addr,
    input  logic [SCALE_W-1:0]       scale_in,
    input  logic [OUT_W-1:0]         bias_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [LANES*OUT_W-1:0]   m_data,
    output logic                     m_last,
    output logic                     busy
);

    phase_t                   r_phase;
    logic [CFG_W-1:0]         r_out_ch;
    logic [CFG_W-1:0]         r_rows;
    logic [CFG_W-1:0]         r_ch_cnt;
    logic [CFG_W-1:0]         r_rg_cnt;
    logic                     r_a_valid;
    logic                     r_a_last;
    logic [ADDR_W-1:0]        r_a_ch;
    logic [LANES*ACC_W-1:0]   r_a_data;
    logic                     r_b_valid;
    logic                     r_b_last;
    logic                     r_c_valid;
    logic                     r_c_last;

    logic w_adv;
    logic w_in_hs;
    logic w_ch_wrap;
    logic w_last_in;
    logic w_out_last_hs;

    assign w_adv         = !r_c_valid || m_ready;
    assign s_ready       = (r_phase == PH_ACCEPT) && w_adv;
    assign w_in_hs       = s_valid && s_ready;
    assign w_ch_wrap     = (r_ch_cnt == r_out_ch - CFG_W'(1));
    assign w_last_in     = w_ch_wrap && (r_rg_cnt == r_rows - CFG_W'(1));
    assign w_out_last_hs = r_c_valid && m_ready && r_c_last;

    // Memory address follows the next channel while flowing, else holds stage A's channel
    assign scale_addr = w_adv ? ADDR_W'(r_ch_cnt) : r_a_ch;
    assign bias_addr  = scale_addr;

    assign m_valid = r_c_valid;
    assign m_last  = r_c_last;
    assign busy    = (r_phase != PH_IDLE);

    // Job phase, config latch and channel/row-group counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_IDLE;
            r_out_ch <= '0;
            r_rows   <= '0;
            r_ch_cnt <= '0;
            r_rg_cnt <= '0;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (start && (out_channels != '0) && (row_groups != '0)) begin
                        r_out_ch <= out_channels;
                        r_rows   <= row_groups;
                        r_ch_cnt <= '0;
                        r_rg_cnt <= '0;
                        r_phase  <= PH_ACCEPT;
                    end
                end
                PH_ACCEPT: begin
                    if (w_in_hs) begin
                        if (w_ch_wrap) begin
                            r_ch_cnt <= '0;
                            r_rg_cnt <= r_rg_cnt + CFG_W'(1);
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CFG_W'(1);
                        end
                        if (w_last_in) begin
                            r_phase <= PH_DRAIN;
                        end
                    end
                end
                PH_DRAIN: begin
                    if (w_out_last_hs) begin
                        r_phase <= PH_IDLE;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    // Stage A capture and valid/last tracking through stages B and C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_a_ch    <= '0;
            r_a_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_last  <= 1'b0;
            r_c_valid <= 1'b0;
            r_c_last  <= 1'b0;
        end else if (w_adv) begin
            r_a_valid <= w_in_hs;
            if (w_in_hs) begin
                r_a_data <= s_data;
                r_a_ch   <= ADDR_W'(r_ch_cnt);
                r_a_last <= w_last_in;
            end
            r_b_valid <= r_a_valid;
            r_b_last  <= r_a_valid && r_a_last;
            r_c_valid <= r_b_valid;
            r_c_last  <= r_b_valid && r_b_last;
        end
    end

    // Per-lane arithmetic, all lanes see the same scale/bias for the channel
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        requant_lane #(
            .ACC_W (ACC_W),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_acc   (r_a_data[gi*ACC_W +: ACC_W]),
            .i_scale (scale_in),
            .i_bias  (bias_in),
            .o_y     (m_data[gi*OUT_W +: OUT_W])
        );
    end

endmodule
